// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory read port, EX redirect and the
// valid/ready handshake towards the decoder.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        id_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output if_valid_o,
    input  id_ready_i,
    output instr_o, pc_o, opcode_o, funct3_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  if_valid_o,
    output id_ready_i,
    input  instr_o, pc_o, opcode_o, funct3_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, credit-limited requests to a 1-cycle imem,
// prefetch FIFO towards decode, flushed by EX redirects.
module fetch_stage_chk #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 2
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic [CNT_W-1:0] count
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CNT_W'(FIFO_DEPTH))));
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      fetch_pc_r;
  logic             inflight_r;
  logic [31:0]      inflight_pc_r;
  logic [31:0]      fifo_instr_r [FIFO_DEPTH];
  logic [31:0]      fifo_pc_r    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_s;
  logic             pop_s;
  logic             push_s;
  logic             req_s;
  logic [CNT_W:0]   occ_s;
  logic [31:0]      addr_s;
  logic [31:0]      instr_s;
  logic [31:0]      pc_s;
  logic             unused_s;

  assign unused_s = ^bus.redirect_pc_i[1:0];
  assign valid_s  = ~reset & (count_r != CNT_W'(0));
  assign pop_s    = valid_s & bus.id_ready_i & ~bus.redirect_i;
  assign push_s   = inflight_r & ~bus.redirect_i;

  // Entries committed once everything in flight lands and this cycle's pop leaves.
  assign occ_s = {1'b0, count_r} + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
  assign req_s = ~reset & ~bus.redirect_i & (occ_s < (CNT_W+1)'(FIFO_DEPTH));

  // Request address and FIFO head, forced to idle values in reset or when empty.
  always_comb begin
    if (reset) begin
      addr_s = 32'h0000_0000;
    end else begin
      addr_s = fetch_pc_r;
    end
    if (valid_s) begin
      instr_s = fifo_instr_r[rd_ptr_r];
      pc_s    = fifo_pc_r[rd_ptr_r];
    end else begin
      instr_s = NOP;
      pc_s    = 32'h0000_0000;
    end
  end

  assign bus.imem_req_o  = req_s;
  assign bus.imem_addr_o = addr_s;
  assign bus.if_valid_o  = valid_s;
  assign bus.instr_o     = instr_s;
  assign bus.pc_o        = pc_s;
  assign bus.opcode_o    = instr_s[6:0];
  assign bus.funct3_o    = instr_s[14:12];

  // PC, in-flight tracking and FIFO pointers; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      rd_ptr_r      <= PTR_W'(0);
      wr_ptr_r      <= PTR_W'(0);
      count_r       <= CNT_W'(0);
    end else if (bus.redirect_i) begin
      fetch_pc_r    <= {bus.redirect_pc_i[31:2], 2'b00};
      inflight_r    <= 1'b0;
      inflight_pc_r <= addr_s;
      rd_ptr_r      <= PTR_W'(0);
      wr_ptr_r      <= PTR_W'(0);
      count_r       <= CNT_W'(0);
    end else begin
      if (req_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      inflight_r    <= req_s;
      inflight_pc_r <= addr_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO payload storage; needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_instr_r[wr_ptr_r] <= bus.imem_rdata_i;
      fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
    end
  end

  fetch_stage_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirects, PC wrap
// and mid-stream reset, against a word-index instruction memory (mem[i] = i).
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   err = 0;

  fetch_stage_if if_lo ();
  fetch_stage_if if_hi ();

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk), .reset (reset), .bus (if_lo.master)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_hi (
    .clk (clk), .reset (reset), .bus (if_hi.master)
  );

  // Instruction memories: one-cycle read, garbage when not requested.
  always_ff @(posedge clk) begin
    if_lo.imem_rdata_i <= if_lo.imem_req_o ? {2'b00, if_lo.imem_addr_o[31:2]} : 32'hDEAD_BEEF;
    if_hi.imem_rdata_i <= if_hi.imem_req_o ? {2'b00, if_hi.imem_addr_o[31:2]} : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    if_lo.redirect_i = 1'b0;
    if_lo.redirect_pc_i = 32'h0;
    if_lo.id_ready_i = rdy;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    #1;
    vec++;
    if (if_lo.imem_req_o !== 1'b0 || if_lo.imem_addr_o !== 32'h0 || if_lo.if_valid_o !== 1'b0 ||
        if_lo.instr_o !== 32'h0000_0013 || if_lo.pc_o !== 32'h0 ||
        if_lo.opcode_o !== 7'h13 || if_lo.funct3_o !== 3'd0) begin
      err++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h op=%h f3=%h, want 0 0 0 00000013 0 13 0",
               if_lo.imem_req_o, if_lo.imem_addr_o, if_lo.if_valid_o, if_lo.instr_o,
               if_lo.pc_o, if_lo.opcode_o, if_lo.funct3_o);
    end
    tick();
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      vec++;
      if (if_lo.imem_req_o !== 1'b1 || if_lo.imem_addr_o !== 32'(4 * c)) begin
        err++;
        $display("FAIL stream_req c=%0d: req=%b addr=%h, want 1 %h", c, if_lo.imem_req_o, if_lo.imem_addr_o, 32'(4 * c));
      end
      vec++;
      if (c < 2) begin
        if (if_lo.if_valid_o !== 1'b0) begin
          err++;
          $display("FAIL stream_fill c=%0d: valid=%b, want 0", c, if_lo.if_valid_o);
        end
      end else if (if_lo.if_valid_o !== 1'b1 || if_lo.pc_o !== 32'(4 * (c - 2)) ||
                   if_lo.instr_o !== 32'(c - 2) || if_lo.opcode_o !== 7'(c - 2)) begin
        err++;
        $display("FAIL stream_head c=%0d: valid=%b pc=%h instr=%h op=%h, want 1 %h %h %h", c,
                 if_lo.if_valid_o, if_lo.pc_o, if_lo.instr_o, if_lo.opcode_o,
                 32'(4 * (c - 2)), 32'(c - 2), 7'(c - 2));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    reset = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if_lo.id_ready_i = (c >= 7);
      #1;
      vec++;
      if (c < 2) begin
        if (if_lo.imem_req_o !== 1'b1 || if_lo.imem_addr_o !== 32'(4 * c) || if_lo.if_valid_o !== 1'b0) begin
          err++;
          $display("FAIL bp_fill c=%0d: req=%b addr=%h valid=%b, want 1 %h 0", c,
                   if_lo.imem_req_o, if_lo.imem_addr_o, if_lo.if_valid_o, 32'(4 * c));
        end
      end else if (c < 7) begin
        if (if_lo.imem_req_o !== 1'b0 || if_lo.if_valid_o !== 1'b1 ||
            if_lo.pc_o !== 32'h0 || if_lo.instr_o !== 32'h0) begin
          err++;
          $display("FAIL bp_stall c=%0d: req=%b valid=%b pc=%h instr=%h, want 0 1 0 0", c,
                   if_lo.imem_req_o, if_lo.if_valid_o, if_lo.pc_o, if_lo.instr_o);
        end
      end else if (if_lo.imem_req_o !== 1'b1 || if_lo.imem_addr_o !== 32'(8 + 4 * (c - 7)) ||
                   if_lo.if_valid_o !== 1'b1 || if_lo.pc_o !== 32'(4 * (c - 7)) ||
                   if_lo.instr_o !== 32'(c - 7)) begin
        err++;
        $display("FAIL bp_resume c=%0d: req=%b addr=%h valid=%b pc=%h instr=%h, want 1 %h 1 %h %h", c,
                 if_lo.imem_req_o, if_lo.imem_addr_o, if_lo.if_valid_o, if_lo.pc_o, if_lo.instr_o,
                 32'(8 + 4 * (c - 7)), 32'(4 * (c - 7)), 32'(c - 7));
      end
      tick();
    end
  endtask

  // After a redirect: two empty cycles requesting base, base+4, then base streams out.
  task automatic check_restart(input string name, input logic [31:0] base);
    for (int c = 0; c < 4; c++) begin
      #1;
      vec++;
      if (c < 2) begin
        if (if_lo.if_valid_o !== 1'b0 || if_lo.imem_req_o !== 1'b1 ||
            if_lo.imem_addr_o !== base + 32'(4 * c)) begin
          err++;
          $display("FAIL %s_refetch c=%0d: valid=%b req=%b addr=%h, want 0 1 %h", name, c,
                   if_lo.if_valid_o, if_lo.imem_req_o, if_lo.imem_addr_o, base + 32'(4 * c));
        end
      end else if (if_lo.if_valid_o !== 1'b1 || if_lo.pc_o !== base + 32'(4 * (c - 2)) ||
                   if_lo.instr_o !== {2'b00, base[31:2]} + 32'(c - 2)) begin
        err++;
        $display("FAIL %s_head c=%0d: valid=%b pc=%h instr=%h, want 1 %h %h", name, c,
                 if_lo.if_valid_o, if_lo.pc_o, if_lo.instr_o, base + 32'(4 * (c - 2)),
                 {2'b00, base[31:2]} + 32'(c - 2));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    if_lo.redirect_i = 1'b1;
    if_lo.redirect_pc_i = 32'h0000_0100;
    #1;
    vec++;
    if (if_lo.imem_req_o !== 1'b0 || if_lo.if_valid_o !== 1'b1 || if_lo.pc_o !== 32'h0000_000C) begin
      err++;
      $display("FAIL redir_cycle: req=%b valid=%b pc=%h, want 0 1 0000000c",
               if_lo.imem_req_o, if_lo.if_valid_o, if_lo.pc_o);
    end
    tick();
    if_lo.redirect_i = 1'b0;
    check_restart("redir100", 32'h0000_0100);
  endtask

  task automatic test_redirect_b2b();
    do_reset(1'b0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    if_lo.id_ready_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if_lo.redirect_i = 1'b1;
      if_lo.redirect_pc_i = (r == 0) ? 32'h0000_0500 : 32'h0000_0203;
      #1;
      vec++;
      if (if_lo.imem_req_o !== 1'b0 || (r == 1 && if_lo.if_valid_o !== 1'b0)) begin
        err++;
        $display("FAIL b2b_redir r=%0d: req=%b valid=%b, want 0 %b", r,
                 if_lo.imem_req_o, if_lo.if_valid_o, (r == 0));
      end
      tick();
    end
    if_lo.redirect_i = 1'b0;
    check_restart("redir203", 32'h0000_0200);
  endtask

  task automatic test_pc_wrap();
    logic [31:0] addr_t [5];
    logic [31:0] pc_t [3];
    logic [31:0] ins_t [3];
    addr_t = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    pc_t   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    ins_t  = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000};
    do_reset(1'b1);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      vec++;
      if (if_hi.imem_req_o !== 1'b1 || if_hi.imem_addr_o !== addr_t[c]) begin
        err++;
        $display("FAIL wrap_req c=%0d: req=%b addr=%h, want 1 %h", c, if_hi.imem_req_o, if_hi.imem_addr_o, addr_t[c]);
      end
      if (c >= 2) begin
        vec++;
        if (if_hi.if_valid_o !== 1'b1 || if_hi.pc_o !== pc_t[c - 2] || if_hi.instr_o !== ins_t[c - 2]) begin
          err++;
          $display("FAIL wrap_head c=%0d: valid=%b pc=%h instr=%h, want 1 %h %h", c,
                   if_hi.if_valid_o, if_hi.pc_o, if_hi.instr_o, pc_t[c - 2], ins_t[c - 2]);
        end
      end
      if (c == 2) begin
        vec++;
        if (if_hi.opcode_o !== 7'h7E || if_hi.funct3_o !== 3'd7) begin
          err++;
          $display("FAIL wrap_slice: op=%h f3=%h, want 7e 7", if_hi.opcode_o, if_hi.funct3_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    if_lo.id_ready_i = 1'b1;
    if_lo.redirect_i = 1'b1;
    if_lo.redirect_pc_i = 32'h0000_0300;
    #1;
    vec++;
    if (if_lo.imem_req_o !== 1'b0 || if_lo.imem_addr_o !== 32'h0 || if_lo.if_valid_o !== 1'b0 ||
        if_lo.instr_o !== 32'h0000_0013 || if_lo.pc_o !== 32'h0) begin
      err++;
      $display("FAIL midreset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, want 0 0 0 00000013 0",
               if_lo.imem_req_o, if_lo.imem_addr_o, if_lo.if_valid_o, if_lo.instr_o, if_lo.pc_o);
    end
    tick();
    reset = 1'b0;
    if_lo.redirect_i = 1'b0;
    check_restart("midreset", 32'h0000_0000);
  endtask

  initial begin
    if_lo.redirect_i = 1'b0;
    if_lo.redirect_pc_i = 32'h0;
    if_lo.id_ready_i = 1'b0;
    if_hi.redirect_i = 1'b0;
    if_hi.redirect_pc_i = 32'h0;
    if_hi.id_ready_i = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_b2b();
    test_pc_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule
